// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the multi-word add sequencer: FSM encoding and the
// chunk-index width helper.
package mwadd_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Index register needs at least one bit even when a word is a single chunk.
   function automatic int idx_width(input int k);
      return (k <= 1) ? 1 : $clog2(k);
   endfunction

endpackage

// File: rtl/multiword_add_sequencer_adder.sv
// N-bit ripple-carry adder used as the shared chunk adder of the sequencer.
module nBitRippleCarryAdder #(
   parameter int N = 8
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign sum[i]       = A[i] ^ B[i] ^ carry[i];
      assign carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
   end

   assign cout = carry[N];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Adds two W-bit words with one N-bit adder over K cycles, carry registered between chunks.
// Build option MWADD_SATURATE_EN: an overflowing result is presented as all-ones.
import mwadd_pkg::*;

module multiword_add_sequencer #(
   parameter  int N = 8,
   parameter  int K = 4,
   localparam int W = N * K
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         busy,
   output logic [1:0]   dbg_state
);

   localparam int IDX_W = idx_width(K);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both
   // high; once raised, out_valid holds with sum/cout stable until out_ready is seen.
   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic [W-1:0]     a_reg;
   logic [W-1:0]     b_reg;
   logic [W-1:0]     acc;
   logic             carry;

   logic [N-1:0]     a_chunk;
   logic [N-1:0]     b_chunk;
   logic [N-1:0]     chunk_sum;
   logic             chunk_cout;
   logic [W-1:0]     acc_next;
   logic [W-1:0]     final_sum;

   always_comb begin
      a_chunk  = '0;
      b_chunk  = '0;
      acc_next = acc;
      for (int i = 0; i < K; i++) begin
         if (idx == IDX_W'(i)) begin
            a_chunk              = a_reg[i*N +: N];
            b_chunk              = b_reg[i*N +: N];
            acc_next[i*N +: N]   = chunk_sum;
         end
      end
   end

   nBitRippleCarryAdder #(.N(N)) u_chunk_adder (
      .A    (a_chunk),
      .B    (b_chunk),
      .cin  (carry),
      .sum  (chunk_sum),
      .cout (chunk_cout)
   );

`ifdef MWADD_SATURATE_EN
   assign final_sum = chunk_cout ? {W{1'b1}} : acc_next;
`else
   assign final_sum = acc_next;
`endif

   assign in_ready  = rst_n && (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN) || (state == DONE);
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  b_reg <= b;
                  carry <= cin;
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               acc   <= acc_next;
               carry <= chunk_cout;
               if (idx == LAST_IDX) begin
                  // Outputs change only here, so they stay put through DONE and IDLE.
                  sum   <= final_sum;
                  cout  <= chunk_cout;
                  idx   <= '0;
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer: a K=4 instance with directed and
// random operations, plus a K=1 instance driven concurrently with random operations.
module tb_multiword_add_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        busy;
   logic [1:0]  dbg_state;

   logic        k1_rst_n;
   logic        k1_in_valid;
   logic        k1_in_ready;
   logic [7:0]  k1_a;
   logic [7:0]  k1_b;
   logic        k1_cin;
   logic        k1_out_valid;
   logic        k1_out_ready;
   logic [7:0]  k1_sum;
   logic        k1_cout;
   logic        k1_busy;
   logic [1:0]  k1_dbg_state;

   int          total = 0;
   int          bad = 0;
   logic        rdy_rand = 1'b0;
   logic        k1_done = 1'b0;

   logic [32:0] exp_q[$];
   logic [8:0]  k1_exp_q[$];

`ifdef MWADD_SATURATE_EN
   localparam logic [31:0] OV_SUM = 32'hFFFF_FFFF;
   localparam logic [7:0]  K1_OV_SUM = 8'hFF;
`else
   localparam logic [31:0] OV_SUM = 32'h0000_0000;
   localparam logic [7:0]  K1_OV_SUM = 8'h00;
`endif

   always #5 clk = ~clk;

   multiword_add_sequencer #(.N(8), .K(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   multiword_add_sequencer #(.N(8), .K(1)) dut_k1 (
      .clk       (clk),
      .rst_n     (k1_rst_n),
      .in_valid  (k1_in_valid),
      .in_ready  (k1_in_ready),
      .a         (k1_a),
      .b         (k1_b),
      .cin       (k1_cin),
      .out_valid (k1_out_valid),
      .out_ready (k1_out_ready),
      .sum       (k1_sum),
      .cout      (k1_cout),
      .busy      (k1_busy),
      .dbg_state (k1_dbg_state)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out", name);
   endtask

   function automatic logic [32:0] gold4(input logic [31:0] va, input logic [31:0] vb,
                                         input logic vc);
      logic [32:0] r;
      r = {1'b0, va} + {1'b0, vb} + {32'd0, vc};
`ifdef MWADD_SATURATE_EN
      if (r[32]) r[31:0] = 32'hFFFF_FFFF;
`endif
      return r;
   endfunction

   function automatic logic [8:0] gold1(input logic [7:0] va, input logic [7:0] vb,
                                        input logic vc);
      logic [8:0] r;
      r = {1'b0, va} + {1'b0, vb} + {8'd0, vc};
`ifdef MWADD_SATURATE_EN
      if (r[8]) r[7:0] = 8'hFF;
`endif
      return r;
   endfunction

   // Monitors: every output handshake pops exactly one expected result.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("k4_unexpected_result", 64'({cout, sum}), 64'h1_0000_0000_0000);
         end else begin
            chk("k4_result", 64'({cout, sum}), 64'(exp_q.pop_front()));
         end
      end
      if (k1_rst_n && k1_out_valid && k1_out_ready) begin
         if (k1_exp_q.size() == 0) begin
            chk("k1_unexpected_result", 64'({k1_cout, k1_sum}), 64'h1_0000_0000_0000);
         end else begin
            chk("k1_result", 64'({k1_cout, k1_sum}), 64'(k1_exp_q.pop_front()));
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
      k1_out_ready = 1'($urandom_range(0, 1));
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send4(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                        input logic [32:0] e);
      logic ok;
      ok = 1'b0;
      a = va;
      b = vb;
      cin = vc;
      in_valid = 1'b1;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
      end
      if (ok) exp_q.push_back(e);
      else timeout("k4_accept");
      #1;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      cin = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_drain4();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) timeout("k4_drain");
      @(posedge clk);
      #1;
   endtask

   initial begin : k1_driver
      logic ok;
      logic [7:0] va;
      logic [7:0] vb;
      logic vc;
      int n;
      k1_rst_n = 1'b0;
      k1_in_valid = 1'b0;
      k1_a = '0;
      k1_b = '0;
      k1_cin = 1'b0;
      k1_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      k1_rst_n = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if (i == 0) begin
            va = 8'hFF; vb = 8'h01; vc = 1'b0;
         end else begin
            va = 8'($urandom); vb = 8'($urandom); vc = 1'($urandom_range(0, 1));
         end
         k1_a = va;
         k1_b = vb;
         k1_cin = vc;
         k1_in_valid = 1'b1;
         ok = 1'b0;
         for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = k1_in_ready;
            @(posedge clk);
         end
         if (!ok) begin
            timeout("k1_accept");
         end else if (i == 0) begin
            k1_exp_q.push_back({1'b1, K1_OV_SUM});
         end else begin
            k1_exp_q.push_back(gold1(va, vb, vc));
         end
         #1;
         k1_in_valid = 1'b0;
         k1_a = 8'($urandom);
      end
      n = 0;
      while (k1_exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) timeout("k1_drain");
      k1_done = 1'b1;
   end

   initial begin : main
      int lat;
      int n;
      logic seen;
      rst_n = 1'b0;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      out_ready = 1'b1;

      repeat (2) @(negedge clk);
      chk("reset_in_ready", 64'(in_ready), 64'(0));
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_sum_cout", 64'({cout, sum}), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;

      // First op also measures accept-to-out_valid latency in edges.
      send4(32'h0000_0003, 32'h0000_0057, 1'b1, {1'b0, 32'h0000_005B});
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         seen = out_valid;
      end
      chk("latency_k4", 64'(lat), 64'(4));
      wait_drain4();

      send4(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {1'b1, OV_SUM});
      wait_drain4();
      send4(32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, OV_SUM});
      wait_drain4();
      send4(32'h0000_FFFF, 32'h0000_0001, 1'b0, {1'b0, 32'h0001_0000});
      wait_drain4();
      send4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {1'b1, 32'hFFFF_FFFF});
      wait_drain4();
      send4(32'h00FF_00FF, 32'h0001_FF01, 1'b0, {1'b0, 32'h0101_0000});
      wait_drain4();

      // Backpressure in DONE with a stray request that must be dropped.
      out_ready = 1'b0;
      send4(32'h1122_3344, 32'h0101_0101, 1'b0, {1'b0, 32'h1223_3445});
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         seen = out_valid;
         n++;
      end
      if (!seen) timeout("bp_out_valid");
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("bp_hold_sum", 64'({cout, sum}), 64'({1'b0, 32'h1223_3445}));
         chk("bp_in_ready", 64'(in_ready), 64'(0));
         chk("bp_state", 64'(dbg_state), 64'(2));
         @(posedge clk);
         #1;
         if (i == 1) begin
            in_valid = 1'b1;
            a = 32'hDEAD_BEEF;
            b = 32'h1234_5678;
         end
         if (i == 2) in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_out_valid", 64'(out_valid), 64'(0));
      chk("bp_release_busy", 64'(busy), 64'(0));
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (busy || out_valid) seen = 1'b1;
      end
      chk("bp_stray_dropped", 64'(seen), 64'(0));
      chk("bp_queue_empty", 64'(exp_q.size()), 64'(0));
      @(posedge clk);
      #1;

      // Reset two RUN cycles into an operation.
      send4(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 33'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("midrun_reset_out_valid", 64'(out_valid), 64'(0));
      chk("midrun_reset_busy", 64'(busy), 64'(0));
      chk("midrun_reset_sum_cout", 64'({cout, sum}), 64'(0));
      chk("midrun_reset_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("midrun_no_out_valid", 64'(seen), 64'(0));
      @(posedge clk);
      #1;
      send4(32'h1234_5678, 32'h1111_1111, 1'b0, {1'b0, 32'h2345_6789});
      wait_drain4();

      rdy_rand = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         logic [31:0] va;
         logic [31:0] vb;
         logic vc;
         va = $urandom;
         vb = $urandom;
         vc = 1'($urandom_range(0, 1));
         send4(va, vb, vc, gold4(va, vb, vc));
      end
      rdy_rand = 1'b0;
      out_ready = 1'b1;
      wait_drain4();

      n = 0;
      while (!k1_done && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (!k1_done) timeout("k1_finish");
      chk("k4_final_queue_empty", 64'(exp_q.size()), 64'(0));
      chk("k1_final_queue_empty", 64'(k1_exp_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
